mem_fifo_ctrl: RTL

First-in first-out queue controller that sits directly upstream of `memory_128byte` (32 lines x 32 bits, single port) and uses it as its storage array. Producers push 32-bit words through a valid/ready port; consumers pop them through a registered valid/ready port. The block arbitrates the single memory port between writes and prefetch reads and keeps occupancy and full/empty status.

---
 rtl/mem_pkg.sv | 16 +
 rtl/fifo_arbiter.sv | 37 +++
 rtl/mem_fifo_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared widths, depth and types for the memory-backed FIFO controller.
// op_t names the single action granted to the memory port each cycle.
package mem_pkg;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_BYPASS = 2'd1,
        OP_WRITE  = 2'd2
    } op_t;
endpackage

// File: rtl/fifo_arbiter.sv
// Purpose: picks READ, BYPASS (MEM_FIFO_BYPASS_EN only) or WRITE for the single memory port.
// Latency: purely combinational, zero cycles.
// Backpressure: in_ready drops during READ or when full; it never looks at in_valid.
module fifo_arbiter (
    input  logic           count_zero,
    input  logic           full,
    input  logic           slot_free,
    input  logic           in_valid,
    output mem_pkg::op_t   op,
    output logic           in_ready,
    output logic           mem_re,
    output logic           mem_we
);
    import mem_pkg::*;

    always_comb begin
        op       = OP_WRITE;
        in_ready = !full;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        if (!count_zero && slot_free) begin
            op       = OP_READ;
            in_ready = 1'b0;
            mem_re   = 1'b1;
        end
`ifdef MEM_FIFO_BYPASS_EN
        else if (slot_free) begin
            op       = OP_BYPASS;
            in_ready = 1'b1;
        end
`endif
        else begin
            // Write strobe only on an accepted push.
            mem_we = in_valid && !full;
        end
    end
endmodule

// File: rtl/mem_fifo_ctrl.sv
// Purpose: FIFO controller using an external 32x32 single-port memory; optional MEM_FIFO_BYPASS_EN.
// Latency: push to out_valid is 1 edge with bypass on an empty queue, otherwise at least 2 edges.
// Backpressure: in_ready low while a prefetch READ owns the port or when memory is full.
module mem_fifo_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              R,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] mem_D,
    output logic [ADDR_W-1:0] mem_A,
    output logic              mem_RE,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_out
);
    import mem_pkg::*;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);

    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic              drain;
    logic              slot_free;
    logic              push;
    op_t               op;

    assign drain     = out_valid && out_ready;
    assign slot_free = !out_valid || drain;
    assign push      = in_valid && in_ready;
    assign full      = (count == DEPTH);
    assign empty     = (count == '0) && !out_valid;

    fifo_arbiter u_arb (
        .count_zero (count == '0),
        .full       (full),
        .slot_free  (slot_free),
        .in_valid   (in_valid),
        .op         (op),
        .in_ready   (in_ready),
        .mem_re     (mem_RE),
        .mem_we     (mem_WE)
    );

    // Address and data stay at zero whenever the port is idle.
    always_comb begin
        mem_A = '0;
        mem_D = '0;
        if (mem_RE) begin
            mem_A = rp;
        end else if (mem_WE) begin
            mem_A = wp;
            mem_D = in_data;
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (op)
                OP_READ: begin
                    out_data  <= mem_out;
                    out_valid <= 1'b1;
                    rp        <= rp + 1'b1;
                    count     <= count - 1'b1;
                end
                OP_BYPASS: begin
                    if (push) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    if (push) begin
                        wp    <= wp + 1'b1;
                        count <= count + 1'b1;
                    end
                    if (drain) begin
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
